weak_sysbus: RTL and testbench

WEAK_SYSBUS -- requirements
Module: weak_sysbus

---
 rtl/weak_sysbus.sv | 255 +++++++++++++++++++++++++
 tb/tb_weak_sysbus.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/weak_sysbus.sv
// weak_sysbus: single-master system bus with word RAM, an 8N1 UART transmitter
// behind a small FIFO, and a three-state (IDLE/ACCESS/RESP) transfer FSM.
module weak_sysbus #(
    parameter int RAM_WORDS  = 1024,
    parameter int UART_DIV   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_req,
    input  logic [31:0] bus_addr,
    input  logic        bus_wr,
    input  logic [3:0]  bus_wr_mask,
    input  logic [31:0] bus_out,
    output logic [31:0] bus_in,
    output logic        bus_ack,
    output logic        uart_tx
);

    localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int DW = (UART_DIV > 1) ? $clog2(UART_DIV) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [DW-1:0] DIV_MAX     = DW'(UART_DIV - 1);
    localparam logic [CW-1:0] FIFO_FULL   = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_MAX     = PW'(FIFO_DEPTH - 1);
    localparam logic [29:0]   UART_DATA_W = 30'h0400_0000;  // 0x1000_0000 >> 2
    localparam logic [29:0]   UART_STAT_W = 30'h0400_0001;  // 0x1000_0004 >> 2

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    // Byte-lane merge: lanes with mask bit set take the new data.
    function automatic logic [31:0] f_merge(input logic [31:0] old_w,
                                            input logic [31:0] new_w,
                                            input logic [3:0]  mask);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Wrapping FIFO pointer increment that also works for non-full-range widths.
    function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] ptr);
        if (ptr == PTR_MAX) begin
            return {PW{1'b0}};
        end else begin
            return ptr + PW'(1);
        end
    endfunction

    // Bus FSM and latched request
    state_t        r_state;
    state_t        w_next;
    logic [29:0]   r_addr;
    logic          r_wr;
    logic [3:0]    r_mask;
    logic [31:0]   r_wdata;
    logic          r_bus_ack;
    logic [31:0]   r_bus_in;

    // Storage
    logic [31:0]   r_mem  [RAM_WORDS];
    logic [7:0]    r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Transmitter
    logic          r_tx_busy;
    logic [DW-1:0] r_div_cnt;
    logic [3:0]    r_bit_cnt;
    logic [9:0]    r_shift;
    logic          r_tx;

    // Decode and control
    logic          w_is_ram;
    logic          w_is_udata;
    logic          w_is_ustat;
    logic [AW-1:0] w_ram_idx;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_frame_end;
    logic          w_fin;
    logic [31:0]   w_rdata;
    logic          w_unused;

    // Byte offset is meaningless on a word bus.
    assign w_unused = ^bus_addr[1:0];

    assign w_is_ram    = (r_addr[29:AW] == {(30-AW){1'b0}});
    assign w_ram_idx   = r_addr[AW-1:0];
    assign w_is_udata  = (r_addr == UART_DATA_W);
    assign w_is_ustat  = (r_addr == UART_STAT_W);
    assign w_full      = (r_count == FIFO_FULL);
    assign w_empty     = (r_count == {CW{1'b0}});
    // Push waits for a free slot; a pop in the same cycle only frees it next cycle.
    assign w_push      = (r_state == S_ACCESS) && r_wr && w_is_udata && !w_full;
    assign w_frame_end = r_tx_busy && (r_div_cnt == DIV_MAX) && (r_bit_cnt == 4'd9);
    assign w_pop       = !w_empty && (!r_tx_busy || w_frame_end);
    assign w_fin       = (r_state == S_ACCESS) && (w_next == S_RESP);

    assign bus_ack = r_bus_ack;
    assign bus_in  = r_bus_in;
    assign uart_tx = r_tx;

    // Bus FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a full FIFO holds a UART_DATA write in ACCESS.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus_req) begin
                    w_next = S_ACCESS;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_ACCESS: begin
                if (r_wr && w_is_udata && w_full) begin
                    w_next = S_ACCESS;
                end else begin
                    w_next = S_RESP;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Capture the request when it is accepted in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= 30'h0;
            r_wr    <= 1'b0;
            r_mask  <= 4'h0;
            r_wdata <= 32'h0;
        end else if ((r_state == S_IDLE) && bus_req) begin
            r_addr  <= bus_addr[31:2];
            r_wr    <= bus_wr;
            r_mask  <= bus_wr_mask;
            r_wdata <= bus_out;
        end
    end

    // Read data source for the access being completed.
    always_comb begin
        w_rdata = 32'h0;
        if (w_is_ram) begin
            w_rdata = r_mem[w_ram_idx];
        end else if (w_is_ustat) begin
            w_rdata = {30'h0, (r_tx_busy || !w_empty), w_full};
        end else begin
            w_rdata = 32'h0;
        end
    end

    // Registered response: ack and read data exist only in the RESP cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bus_ack <= 1'b0;
            r_bus_in  <= 32'h0;
        end else begin
            r_bus_ack <= w_fin;
            r_bus_in  <= (w_fin && !r_wr) ? w_rdata : 32'h0;
        end
    end

    // RAM write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if ((r_state == S_ACCESS) && r_wr && w_is_ram) begin
            r_mem[w_ram_idx] <= f_merge(r_mem[w_ram_idx], r_wdata, r_mask);
        end
    end

    // FIFO data storage.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= r_wdata[7:0];
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= f_ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // 8N1 transmitter; a pop at the end of a stop bit starts the next frame with no gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_busy <= 1'b0;
            r_div_cnt <= {DW{1'b0}};
            r_bit_cnt <= 4'd0;
            r_shift   <= 10'h3FF;
            r_tx      <= 1'b1;
        end else if (w_pop) begin
            r_tx_busy <= 1'b1;
            r_div_cnt <= {DW{1'b0}};
            r_bit_cnt <= 4'd0;
            r_shift   <= {1'b1, r_fifo[r_rd_ptr], 1'b0};
            r_tx      <= 1'b0;
        end else if (r_tx_busy) begin
            if (r_div_cnt == DIV_MAX) begin
                r_div_cnt <= {DW{1'b0}};
                if (r_bit_cnt == 4'd9) begin
                    r_tx_busy <= 1'b0;
                    r_tx      <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                    r_shift   <= {1'b1, r_shift[9:1]};
                    r_tx      <= r_shift[1];
                end
            end else begin
                r_div_cnt <= r_div_cnt + DW'(1);
            end
        end
    end

endmodule

// File: tb/tb_weak_sysbus.sv
// Directed, table-driven bench for weak_sysbus with a UART frame receiver.
module tb_weak_sysbus;

    localparam int DIV = 4;

    logic        clk;
    logic        rst;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic        bus_wr;
    logic [3:0]  bus_wr_mask;
    logic [31:0] bus_out;
    logic [31:0] bus_in;
    logic        bus_ack;
    logic        uart_tx;

    int checks = 0;
    int errors = 0;
    int idle_nz = 0;

    weak_sysbus #(.RAM_WORDS(1024), .UART_DIV(DIV), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .bus_req(bus_req), .bus_addr(bus_addr),
        .bus_wr(bus_wr), .bus_wr_mask(bus_wr_mask), .bus_out(bus_out),
        .bus_in(bus_in), .bus_ack(bus_ack), .uart_tx(uart_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // UART receiver model: samples the centre of every bit of each frame.
    logic [7:0] rx_q[$];
    logic       rx_busy = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_sh = 8'h00;
    int         rx_ferr = 0;

    always @(negedge clk) begin
        if (rst) begin
            rx_busy <= 1'b0;
            rx_cnt  <= 0;
        end else if (!rx_busy) begin
            if (uart_tx == 1'b0) begin
                rx_busy <= 1'b1;
                rx_cnt  <= 1;
            end
        end else begin
            if (rx_cnt >= 6 && rx_cnt <= 34 && (rx_cnt % 4) == 2) rx_sh <= {uart_tx, rx_sh[7:1]};
            if (rx_cnt == 38 && uart_tx !== 1'b1) rx_ferr <= rx_ferr + 1;
            if (rx_cnt == 39) begin
                rx_busy <= 1'b0;
                rx_q.push_back(rx_sh);
            end
            rx_cnt <= rx_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // One bus transfer; returns read data and request-to-ack latency in cycles.
    task automatic xfer(input logic [31:0] a, input logic w, input logic [3:0] m,
                        input logic [31:0] d, input bit now,
                        output logic [31:0] rd, output int lat);
        bit got;
        if (!now) begin
            @(posedge clk);
            #1;
        end
        bus_req = 1'b1; bus_addr = a; bus_wr = w; bus_wr_mask = m; bus_out = d;
        lat = 0; rd = 32'h0; got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus_ack) begin
                got = 1'b1;
                rd = bus_in;
            end else if (bus_in !== 32'h0) begin
                idle_nz++;
            end
        end
        bus_req = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL xfer_timeout addr=%h actual=no_ack expected=ack", a);
        end
    endtask

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  mask;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [23];

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin : main
        logic [31:0] rd;
        int          lat;
        logic [9:0]  frame;
        int          base;
        int          bad;
        bit          fell;

        // A byte write is presented on its own lane (byte 0xAA at 0x12 -> lane 2).
        vecs[0]  = '{32'h0000_0010, 1'b1, 4'hF,    32'hDEAD_BEEF, 32'h0};
        vecs[1]  = '{32'h0000_0010, 1'b0, 4'h0,    32'h0,         32'hDEAD_BEEF};
        vecs[2]  = '{32'h0000_0012, 1'b1, 4'b0100, 32'h00AA_0000, 32'h0};
        vecs[3]  = '{32'h0000_0010, 1'b0, 4'h0,    32'h0,         32'hDEAA_BEEF};
        vecs[4]  = '{32'h0000_0014, 1'b1, 4'hF,    32'h1234_5678, 32'h0};
        vecs[5]  = '{32'h0000_0014, 1'b1, 4'h0,    32'hFFFF_FFFF, 32'h0};
        vecs[6]  = '{32'h0000_0014, 1'b0, 4'h0,    32'h0,         32'h1234_5678};
        vecs[7]  = '{32'h0000_0018, 1'b1, 4'hF,    32'h1122_3344, 32'h0};
        vecs[8]  = '{32'h0000_0018, 1'b1, 4'b1001, 32'hAABB_CCDD, 32'h0};
        vecs[9]  = '{32'h0000_001B, 1'b0, 4'h0,    32'h0,         32'hAA22_33DD};
        vecs[10] = '{32'h0000_0000, 1'b1, 4'hF,    32'hCAFE_F00D, 32'h0};
        vecs[11] = '{32'h2000_0000, 1'b1, 4'hF,    32'hFFFF_FFFF, 32'h0};
        vecs[12] = '{32'h0000_1000, 1'b1, 4'hF,    32'h0BAD_BEEF, 32'h0};
        vecs[13] = '{32'h0000_0000, 1'b0, 4'h0,    32'h0,         32'hCAFE_F00D};
        vecs[14] = '{32'h2000_0000, 1'b0, 4'h0,    32'h0,         32'h0};
        vecs[15] = '{32'h0000_1000, 1'b0, 4'h0,    32'h0,         32'h0};
        vecs[16] = '{32'h0000_0FFC, 1'b1, 4'hF,    32'h600D_CAFE, 32'h0};
        vecs[17] = '{32'h0000_0FFC, 1'b0, 4'h0,    32'h0,         32'h600D_CAFE};
        vecs[18] = '{32'h1000_0004, 1'b0, 4'h0,    32'h0,         32'h0};
        vecs[19] = '{32'h1000_0000, 1'b0, 4'h0,    32'h0,         32'h0};
        vecs[20] = '{32'h1000_0004, 1'b1, 4'hF,    32'hFFFF_FFFF, 32'h0};
        vecs[21] = '{32'h1000_0004, 1'b0, 4'h0,    32'h0,         32'h0};
        vecs[22] = '{32'h1000_0008, 1'b0, 4'h0,    32'h0,         32'h0};

        rst = 1'b1; bus_req = 1'b0; bus_addr = 32'h0; bus_wr = 1'b0;
        bus_wr_mask = 4'h0; bus_out = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ack", {31'h0, bus_ack}, 32'h0);
        chk("reset_bus_in", bus_in, 32'h0);
        chk("reset_uart_tx", {31'h0, uart_tx}, 32'h1);

        // First request presented together with reset release.
        @(negedge clk);
        rst = 1'b0;
        xfer(32'h0000_0040, 1'b1, 4'hF, 32'h5A5A_A5A5, 1'b1, rd, lat);
        chk("first_req_latency", 32'(lat), 32'd2);

        foreach (vecs[i]) begin
            xfer(vecs[i].addr, vecs[i].wr, vecs[i].mask, vecs[i].wdata, 1'b0, rd, lat);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_ack_pulse", i), {31'h0, bus_ack}, 32'h0);
        end

        // Single frame of 0x55: ten bits of DIV cycles each, then idle high.
        base = rx_q.size();
        xfer(32'h1000_0000, 1'b1, 4'h0, 32'h0000_0055, 1'b0, rd, lat);
        chk("uart_wr_latency", 32'(lat), 32'd2);
        fell = 1'b0;
        for (int i = 0; i < 20 && !fell; i++) begin
            @(negedge clk);
            if (uart_tx == 1'b0) fell = 1'b1;
        end
        chk("uart_start_seen", {31'h0, fell}, 32'h1);
        frame = {1'b1, 8'h55, 1'b0};
        for (int k = 0; k < 44; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("tx_bit_k%0d", k), {31'h0, uart_tx},
                (k < 40) ? {31'h0, frame[k/4]} : 32'h1);
        end
        chk("rx_count_55", 32'(rx_q.size() - base), 32'd1);
        if (rx_q.size() > base) chk("rx_byte_55", {24'h0, rx_q[base]}, 32'h55);

        // Six back-to-back UART writes: the sixth stalls until a slot frees.
        base = rx_q.size();
        for (int i = 0; i < 5; i++) begin
            xfer(32'h1000_0000, 1'b1, 4'hF, 32'(8'hA1 + i), 1'b0, rd, lat);
            chk($sformatf("burst_wr%0d_latency", i + 1), 32'(lat), 32'd2);
        end
        xfer(32'h1000_0004, 1'b0, 4'h0, 32'h0, 1'b0, rd, lat);
        chk("stat_full", rd, 32'h3);
        xfer(32'h1000_0000, 1'b1, 4'hF, 32'h0000_00A6, 1'b0, rd, lat);
        // Slot frees at the end of the first 40-cycle frame, roughly 25 cycles later.
        chk("burst_wr6_stalled", {31'h0, (lat >= 20 && lat <= 30)}, 32'h1);
        xfer(32'h1000_0004, 1'b0, 4'h0, 32'h0, 1'b0, rd, lat);
        chk("stat_full_again", rd, 32'h3);
        rd = 32'h3;
        for (int i = 0; i < 400 && rd != 32'h0; i++) begin
            xfer(32'h1000_0004, 1'b0, 4'h0, 32'h0, 1'b0, rd, lat);
        end
        chk("stat_drained", rd, 32'h0);
        chk("rx_count_burst", 32'(rx_q.size() - base), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (rx_q.size() > base + i)
                chk($sformatf("rx_byte%0d", i), {24'h0, rx_q[base + i]}, 32'(8'hA1 + i));
        end
        chk("rx_framing", 32'(rx_ferr), 32'd0);

        // Reset during a RAM read ACCESS while a frame of 0x00 is on the line.
        for (int i = 0; i < 3; i++) begin
            xfer(32'h1000_0000, 1'b1, 4'hF, 32'h0, 1'b0, rd, lat);
        end
        repeat (6) @(posedge clk);
        #1;
        bus_req = 1'b1; bus_addr = 32'h0000_0040; bus_wr = 1'b0; bus_wr_mask = 4'h0;
        @(posedge clk);
        #1;
        chk("pre_reset_tx_low", {31'h0, uart_tx}, 32'h0);
        chk("pre_reset_no_ack", {31'h0, bus_ack}, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("reset_tx_high_now", {31'h0, uart_tx}, 32'h1);
        chk("reset_ack_now", {31'h0, bus_ack}, 32'h0);
        chk("reset_bus_in_now", bus_in, 32'h0);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (bus_ack !== 1'b0 || uart_tx !== 1'b1) bad++;
        end
        chk("reset_held_quiet", 32'(bad), 32'd0);
        bus_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        xfer(32'h1000_0004, 1'b0, 4'h0, 32'h0, 1'b0, rd, lat);
        chk("post_reset_stat", rd, 32'h0);
        xfer(32'h0000_0040, 1'b0, 4'h0, 32'h0, 1'b0, rd, lat);
        chk("ram_survives_reset", rd, 32'h5A5A_A5A5);
        chk("post_reset_latency", 32'(lat), 32'd2);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) bad++;
        end
        chk("post_reset_tx_idle", 32'(bad), 32'd0);

        chk("bus_in_zero_outside_resp", 32'(idle_nz), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
